// File: rtl/alu_arb.sv
// alu_arb: two-port round-robin arbiter in front of the shared multi-cycle ALU.
// Requester 0 is the operand pass, requester 1 the branch/jump address pass.
// The winner's operands are latched into the alu_* registers and held for the
// whole operation. The result comes back with a one-cycle done pulse. An
// operation is aborted by a pipeline flush or when the ALU does not ack within
// TIMEOUT cycles.
//
// Ports:
//   clk, rst (sync, active-low), flush
//   reqN_valid/op/opr1/opr2/c   request N (N = 0, 1), held until reqN_ready
//   reqN_ready/done/err         one-cycle pulses: accepted / result valid / timed out
//   res                         last completed result
//   busy, owner                 operation in flight / current or last grantee
//   alu_run/op/opr1/opr2/c      registered ALU command
//   alu_ans, alu_ack            ALU result and level completion flag
module alu_arb #(
  parameter int REG_SZ  = 32,
  parameter int TIMEOUT = 16,
  parameter int ALUOP_L = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req0_valid,
  input  logic [ALUOP_L-1:0] req0_op,
  input  logic [REG_SZ-1:0]  req0_opr1,
  input  logic [REG_SZ-1:0]  req0_opr2,
  input  logic               req0_c,
  output logic               req0_ready,
  output logic               req0_done,
  output logic               req0_err,
  input  logic               req1_valid,
  input  logic [ALUOP_L-1:0] req1_op,
  input  logic [REG_SZ-1:0]  req1_opr1,
  input  logic [REG_SZ-1:0]  req1_opr2,
  input  logic               req1_c,
  output logic               req1_ready,
  output logic               req1_done,
  output logic               req1_err,
  output logic [REG_SZ-1:0]  res,
  output logic               busy,
  output logic               owner,
  output logic               alu_run,
  output logic [ALUOP_L-1:0] alu_op,
  output logic [REG_SZ-1:0]  alu_opr1,
  output logic [REG_SZ-1:0]  alu_opr2,
  output logic               alu_c,
  input  logic [REG_SZ-1:0]  alu_ans,
  input  logic               alu_ack
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               last;
  logic [7:0]         cnt;
  logic               ack_q;

  logic               grant_vld;
  logic               grant_idx;
  logic [ALUOP_L-1:0] win_op;
  logic [REG_SZ-1:0]  win_opr1;
  logic [REG_SZ-1:0]  win_opr2;
  logic               win_c;
  logic               ack_edge;
  logic               timeout_hit;

  // Cycle counter in RUN; it never wraps back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Arbitration: a lone request wins; on contention the one not granted last wins.
  always_comb begin
    grant_vld   = !flush && (req0_valid || req1_valid);
    grant_idx   = (req0_valid && req1_valid) ? ~last : req1_valid;
    win_op      = grant_idx ? req1_op   : req0_op;
    win_opr1    = grant_idx ? req1_opr1 : req0_opr1;
    win_opr2    = grant_idx ? req1_opr2 : req0_opr2;
    win_c       = grant_idx ? req1_c    : req0_c;
    // Only a rising ack completes; a level left over from an earlier op does not.
    ack_edge    = alu_ack && !ack_q;
    timeout_hit = (cnt == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      cnt        <= '0;
      ack_q      <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      alu_run    <= 1'b0;
      alu_op     <= '0;
      alu_opr1   <= '0;
      alu_opr2   <= '0;
      alu_c      <= 1'b0;
      res        <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
    end else begin
      ack_q      <= alu_ack;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            alu_op     <= win_op;
            alu_opr1   <= win_opr1;
            alu_opr2   <= win_opr2;
            alu_c      <= win_c;
            alu_run    <= 1'b1;
            busy       <= 1'b1;
            owner      <= grant_idx;
            last       <= grant_idx;
            cnt        <= '0;
            req0_ready <= !grant_idx;
            req1_ready <= grant_idx;
            state      <= RUN;
          end
        end
        RUN: begin
          // Priority: flush, then completion, then timeout.
          if (flush) begin
            alu_run <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (ack_edge) begin
            res       <= alu_ans;
            req0_done <= !owner;
            req1_done <= owner;
            alu_run   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            req0_err <= !owner;
            req1_err <= owner;
            alu_run  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
